// File: rtl/alu_rs_if.sv
// Issue / CDB / dispatch bundle of the ALU reservation station.
// master = issue+CDB side driving the station; slave = the station itself.
interface alu_rs_if #(
  parameter int ROB_W = 4
);
  logic             issue_valid;
  logic [6:0]       issue_opcode;
  logic [2:0]       issue_funct3;
  logic             issue_funct7;
  logic             issue_rs1_ready;
  logic [31:0]      issue_rs1_val;
  logic [ROB_W-1:0] issue_rs1_tag;
  logic             issue_rs2_ready;
  logic [31:0]      issue_rs2_val;
  logic [ROB_W-1:0] issue_rs2_tag;
  logic [31:0]      issue_imm;
  logic [31:0]      issue_pc;
  logic [ROB_W-1:0] issue_rob_pos;
  logic             rs_full;

  logic             alu_cdb_valid;
  logic [ROB_W-1:0] alu_cdb_rob_pos;
  logic [31:0]      alu_cdb_val;
  logic             lsb_cdb_valid;
  logic [ROB_W-1:0] lsb_cdb_rob_pos;
  logic [31:0]      lsb_cdb_val;

  logic             alu_en;
  logic [6:0]       alu_opcode;
  logic [2:0]       alu_funct3;
  logic             alu_funct7;
  logic [31:0]      alu_val1;
  logic [31:0]      alu_val2;
  logic [31:0]      alu_imm;
  logic [31:0]      alu_pc;
  logic [ROB_W-1:0] alu_rob_pos;

  modport master (
    output issue_valid, issue_opcode, issue_funct3, issue_funct7,
           issue_rs1_ready, issue_rs1_val, issue_rs1_tag,
           issue_rs2_ready, issue_rs2_val, issue_rs2_tag,
           issue_imm, issue_pc, issue_rob_pos,
           alu_cdb_valid, alu_cdb_rob_pos, alu_cdb_val,
           lsb_cdb_valid, lsb_cdb_rob_pos, lsb_cdb_val,
    input  rs_full, alu_en, alu_opcode, alu_funct3, alu_funct7,
           alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
  );
  modport slave (
    input  issue_valid, issue_opcode, issue_funct3, issue_funct7,
           issue_rs1_ready, issue_rs1_val, issue_rs1_tag,
           issue_rs2_ready, issue_rs2_val, issue_rs2_tag,
           issue_imm, issue_pc, issue_rob_pos,
           alu_cdb_valid, alu_cdb_rob_pos, alu_cdb_val,
           lsb_cdb_valid, lsb_cdb_rob_pos, lsb_cdb_val,
    output rs_full, alu_en, alu_opcode, alu_funct3, alu_funct7,
           alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: per-slot operand capture from ALU/LSB CDBs, one registered dispatch per cycle.
// Define RS_AGE_SELECT_EN to select the oldest ready entry (age matrix) instead of the lowest index.
module alu_rs_slot #(
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             ins_i,
  input  logic             disp_i,
  input  logic [6:0]       op_i,
  input  logic [2:0]       f3_i,
  input  logic             f7_i,
  input  logic [31:0]      imm_i,
  input  logic [31:0]      pc_i,
  input  logic [ROB_W-1:0] rob_i,
  input  logic             p1_i,
  input  logic             p2_i,
  input  logic [ROB_W-1:0] q1_i,
  input  logic [ROB_W-1:0] q2_i,
  input  logic [31:0]      v1_i,
  input  logic [31:0]      v2_i,
  input  logic             acdb_v_i,
  input  logic [ROB_W-1:0] acdb_tag_i,
  input  logic [31:0]      acdb_val_i,
  input  logic             lcdb_v_i,
  input  logic [ROB_W-1:0] lcdb_tag_i,
  input  logic [31:0]      lcdb_val_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [6:0]       op_o,
  output logic [2:0]       f3_o,
  output logic             f7_o,
  output logic [31:0]      v1_o,
  output logic [31:0]      v2_o,
  output logic [31:0]      imm_o,
  output logic [31:0]      pc_o,
  output logic [ROB_W-1:0] rob_o
);
  logic             busy_q, p1_q, p2_q, p1_d, p2_d, f7_q;
  logic [6:0]       op_q;
  logic [2:0]       f3_q;
  logic [ROB_W-1:0] q1_q, q2_q, rob_q;
  logic [31:0]      v1_q, v2_q, v1_d, v2_d, imm_q, pc_q;

  // Pending flag implies busy, so no busy gating on the tag match; ALU wins a tie.
  always_comb begin
    p1_d = p1_q; v1_d = v1_q;
    p2_d = p2_q; v2_d = v2_q;
    if (p1_q && acdb_v_i && acdb_tag_i == q1_q)      begin p1_d = 1'b0; v1_d = acdb_val_i; end
    else if (p1_q && lcdb_v_i && lcdb_tag_i == q1_q) begin p1_d = 1'b0; v1_d = lcdb_val_i; end
    if (p2_q && acdb_v_i && acdb_tag_i == q2_q)      begin p2_d = 1'b0; v2_d = acdb_val_i; end
    else if (p2_q && lcdb_v_i && lcdb_tag_i == q2_q) begin p2_d = 1'b0; v2_d = lcdb_val_i; end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0; p1_q <= 1'b0; p2_q <= 1'b0;
      op_q <= '0; f3_q <= '0; f7_q <= 1'b0; imm_q <= '0; pc_q <= '0; rob_q <= '0;
      q1_q <= '0; q2_q <= '0; v1_q <= '0; v2_q <= '0;
    end else if (en_i) begin
      if (flush_i) begin
        busy_q <= 1'b0; p1_q <= 1'b0; p2_q <= 1'b0;
      end else if (ins_i) begin
        busy_q <= 1'b1;
        op_q <= op_i; f3_q <= f3_i; f7_q <= f7_i; imm_q <= imm_i; pc_q <= pc_i; rob_q <= rob_i;
        p1_q <= p1_i; q1_q <= q1_i; v1_q <= v1_i;
        p2_q <= p2_i; q2_q <= q2_i; v2_q <= v2_i;
      end else begin
        if (disp_i) busy_q <= 1'b0;
        p1_q <= p1_d; v1_q <= v1_d;
        p2_q <= p2_d; v2_q <= v2_d;
      end
    end
  end

  assign busy_o  = busy_q;
  assign ready_o = busy_q & ~p1_q & ~p2_q;
  assign op_o  = op_q;  assign f3_o = f3_q; assign f7_o = f7_q;
  assign v1_o  = v1_q;  assign v2_o = v2_q;
  assign imm_o = imm_q; assign pc_o = pc_q; assign rob_o = rob_q;
endmodule

module alu_rs #(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4,
  parameter int ROB_W    = 4
) (
  input logic   clk,
  input logic   rst,
  input logic   rdy_i,
  input logic   rollback_i,
  alu_rs_if.slave bus
);
  logic [RS_SIZE-1:0]            busy, ready, ins_vec, disp_vec;
  logic [RS_SIZE-1:0][6:0]       op;
  logic [RS_SIZE-1:0][2:0]       f3;
  logic [RS_SIZE-1:0]            f7;
  logic [RS_SIZE-1:0][31:0]      v1, v2, imm, pc;
  logic [RS_SIZE-1:0][ROB_W-1:0] rob;
  logic [RS_IDX_W-1:0]           free_idx, sel_idx;
  logic                          has_free, sel_vld, do_ins;
  logic                          s1_pend, s2_pend;
  logic [31:0]                   s1_val, s2_val;

  // Insert-time bypass: operand broadcast in the issue cycle is captured directly.
  always_comb begin
    s1_pend = 1'b0; s1_val = bus.issue_rs1_val;
    s2_pend = 1'b0; s2_val = bus.issue_rs2_val;
    if (!bus.issue_rs1_ready) begin
      if (bus.alu_cdb_valid && bus.alu_cdb_rob_pos == bus.issue_rs1_tag)      s1_val = bus.alu_cdb_val;
      else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_pos == bus.issue_rs1_tag) s1_val = bus.lsb_cdb_val;
      else s1_pend = 1'b1;
    end
    if (!bus.issue_rs2_ready) begin
      if (bus.alu_cdb_valid && bus.alu_cdb_rob_pos == bus.issue_rs2_tag)      s2_val = bus.alu_cdb_val;
      else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_pos == bus.issue_rs2_tag) s2_val = bus.lsb_cdb_val;
      else s2_pend = 1'b1;
    end
  end

  always_comb begin
    has_free = 1'b0; free_idx = '0;
    for (int i = RS_SIZE-1; i >= 0; i--)
      if (!busy[i]) begin has_free = 1'b1; free_idx = RS_IDX_W'(i); end
  end

`ifdef RS_AGE_SELECT_EN
  // age_q[i][j] = 1: entry j is older than entry i.
  logic [RS_SIZE-1:0][RS_SIZE-1:0] age_q;

  always_comb begin
    sel_vld = 1'b0; sel_idx = '0;
    for (int i = 0; i < RS_SIZE; i++)
      if (ready[i] && (age_q[i] & ready) == '0) begin sel_vld = 1'b1; sel_idx = RS_IDX_W'(i); end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) age_q <= '0;
    else if (rdy_i) begin
      if (rollback_i) age_q <= '0;
      else
        for (int i = 0; i < RS_SIZE; i++)
          for (int j = 0; j < RS_SIZE; j++)
            if (ins_vec[i])                                 age_q[i][j] <= busy[j] & ~disp_vec[j];
            else if (disp_vec[i] || disp_vec[j] || ins_vec[j]) age_q[i][j] <= 1'b0;
    end
  end
`else
  always_comb begin
    sel_vld = 1'b0; sel_idx = '0;
    for (int i = RS_SIZE-1; i >= 0; i--)
      if (ready[i]) begin sel_vld = 1'b1; sel_idx = RS_IDX_W'(i); end
  end
`endif

  assign bus.rs_full = &busy;
  assign do_ins      = bus.issue_valid & has_free;
  assign ins_vec     = RS_SIZE'(do_ins) << free_idx;
  assign disp_vec    = RS_SIZE'(sel_vld) << sel_idx;

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_slot
    alu_rs_slot #(.ROB_W(ROB_W)) u_slot (
      .clk(clk), .rst(rst), .en_i(rdy_i), .flush_i(rollback_i),
      .ins_i(ins_vec[g]), .disp_i(disp_vec[g]),
      .op_i(bus.issue_opcode), .f3_i(bus.issue_funct3), .f7_i(bus.issue_funct7),
      .imm_i(bus.issue_imm), .pc_i(bus.issue_pc), .rob_i(bus.issue_rob_pos),
      .p1_i(s1_pend), .p2_i(s2_pend), .q1_i(bus.issue_rs1_tag), .q2_i(bus.issue_rs2_tag),
      .v1_i(s1_val), .v2_i(s2_val),
      .acdb_v_i(bus.alu_cdb_valid), .acdb_tag_i(bus.alu_cdb_rob_pos), .acdb_val_i(bus.alu_cdb_val),
      .lcdb_v_i(bus.lsb_cdb_valid), .lcdb_tag_i(bus.lsb_cdb_rob_pos), .lcdb_val_i(bus.lsb_cdb_val),
      .busy_o(busy[g]), .ready_o(ready[g]),
      .op_o(op[g]), .f3_o(f3[g]), .f7_o(f7[g]), .v1_o(v1[g]), .v2_o(v2[g]),
      .imm_o(imm[g]), .pc_o(pc[g]), .rob_o(rob[g])
    );
  end

  logic             en_q, f7_q;
  logic [6:0]       op_q;
  logic [2:0]       f3_q;
  logic [31:0]      v1_q, v2_q, imm_q, pc_q;
  logic [ROB_W-1:0] rob_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= 1'b0; op_q <= '0; f3_q <= '0; f7_q <= 1'b0;
      v1_q <= '0; v2_q <= '0; imm_q <= '0; pc_q <= '0; rob_q <= '0;
    end else if (!rdy_i) begin
      en_q <= 1'b0;
    end else if (rollback_i) begin
      en_q <= 1'b0; op_q <= '0; f3_q <= '0; f7_q <= 1'b0;
      v1_q <= '0; v2_q <= '0; imm_q <= '0; pc_q <= '0; rob_q <= '0;
    end else if (sel_vld) begin
      en_q <= 1'b1; op_q <= op[sel_idx]; f3_q <= f3[sel_idx]; f7_q <= f7[sel_idx];
      v1_q <= v1[sel_idx]; v2_q <= v2[sel_idx]; imm_q <= imm[sel_idx];
      pc_q <= pc[sel_idx]; rob_q <= rob[sel_idx];
    end else begin
      en_q <= 1'b0;
    end
  end

  assign bus.alu_en     = en_q;
  assign bus.alu_opcode = op_q;  assign bus.alu_funct3 = f3_q; assign bus.alu_funct7 = f7_q;
  assign bus.alu_val1   = v1_q;  assign bus.alu_val2   = v2_q;
  assign bus.alu_imm    = imm_q; assign bus.alu_pc     = pc_q; assign bus.alu_rob_pos = rob_q;
endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: reference model of the station (entry list + age counter) checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alu_rs;
  localparam int N = 16;
`ifdef RS_AGE_SELECT_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] ADD  = 7'b0110011;

  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, rollback = 1'b0;
  alu_rs_if #(.ROB_W(4)) bus();
  alu_rs #(.RS_SIZE(N), .RS_IDX_W(4), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy_i(rdy), .rollback_i(rollback), .bus(bus)
  );
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic busy, p1, p2, f7;
    logic [6:0] op; logic [2:0] f3;
    logic [31:0] v1, v2, imm, pc;
    logic [3:0] q1, q2, rob;
    int seq;
  } ent_t;
  ent_t m[N];
  logic m_en = 1'b0, m_full = 1'b0, m_f7;
  logic [6:0] m_op; logic [2:0] m_f3; logic [3:0] m_rob;
  logic [31:0] m_v1, m_v2, m_imm, m_pc;
  int seq_ctr = 0;

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin m[i].busy = 0; m[i].p1 = 0; m[i].p2 = 0; end
    m_en = 0; m_full = 0; m_op = 0; m_f3 = 0; m_f7 = 0;
    m_v1 = 0; m_v2 = 0; m_imm = 0; m_pc = 0; m_rob = 0;
  endtask

  task automatic m_src(input logic r, input logic [31:0] v, input logic [3:0] t,
                       output logic p, output logic [31:0] ov);
    p = 0; ov = v;
    if (!r) begin
      if (bus.alu_cdb_valid && bus.alu_cdb_rob_pos == t)      ov = bus.alu_cdb_val;
      else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_pos == t) ov = bus.lsb_cdb_val;
      else p = 1;
    end
  endtask

  task automatic m_step();
    int sel, fr;
    sel = -1; fr = -1;
    for (int i = 0; i < N; i++)
      if (m[i].busy && !m[i].p1 && !m[i].p2)
        if (sel < 0 || (AGE && m[i].seq < m[sel].seq)) sel = i;
    for (int i = N-1; i >= 0; i--) if (!m[i].busy) fr = i;
    m_en = 0;
    if (sel >= 0) begin
      m_en = 1; m_op = m[sel].op; m_f3 = m[sel].f3; m_f7 = m[sel].f7;
      m_v1 = m[sel].v1; m_v2 = m[sel].v2; m_imm = m[sel].imm; m_pc = m[sel].pc; m_rob = m[sel].rob;
      m[sel].busy = 0;
    end
    for (int i = 0; i < N; i++) if (m[i].busy) begin
      if (m[i].p1) begin
        if (bus.alu_cdb_valid && bus.alu_cdb_rob_pos == m[i].q1) begin m[i].v1 = bus.alu_cdb_val; m[i].p1 = 0; end
        else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_pos == m[i].q1) begin m[i].v1 = bus.lsb_cdb_val; m[i].p1 = 0; end
      end
      if (m[i].p2) begin
        if (bus.alu_cdb_valid && bus.alu_cdb_rob_pos == m[i].q2) begin m[i].v2 = bus.alu_cdb_val; m[i].p2 = 0; end
        else if (bus.lsb_cdb_valid && bus.lsb_cdb_rob_pos == m[i].q2) begin m[i].v2 = bus.lsb_cdb_val; m[i].p2 = 0; end
      end
    end
    // fr was found on the pre-dispatch occupancy: a slot freed now is not reusable yet
    if (bus.issue_valid && fr >= 0) begin
      m[fr].busy = 1; m[fr].op = bus.issue_opcode; m[fr].f3 = bus.issue_funct3; m[fr].f7 = bus.issue_funct7;
      m[fr].imm = bus.issue_imm; m[fr].pc = bus.issue_pc; m[fr].rob = bus.issue_rob_pos;
      m[fr].q1 = bus.issue_rs1_tag; m[fr].q2 = bus.issue_rs2_tag;
      m_src(bus.issue_rs1_ready, bus.issue_rs1_val, bus.issue_rs1_tag, m[fr].p1, m[fr].v1);
      m_src(bus.issue_rs2_ready, bus.issue_rs2_val, bus.issue_rs2_tag, m[fr].p2, m[fr].v2);
      m[fr].seq = seq_ctr++;
    end
    m_full = 1;
    for (int i = 0; i < N; i++) if (!m[i].busy) m_full = 0;
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_clear();
      else if (!rdy) m_en = 0;
      else if (rollback) m_clear();
      else m_step();
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(posedge clk); #1;
    chk("m_alu_en", bus.alu_en, m_en);
    chk("m_rs_full", bus.rs_full, m_full);
    if (m_en) begin
      chk("m_opcode", bus.alu_opcode, m_op);
      chk("m_funct3", bus.alu_funct3, m_f3);
      chk("m_funct7", bus.alu_funct7, m_f7);
      chk("m_val1", bus.alu_val1, m_v1);
      chk("m_val2", bus.alu_val2, m_v2);
      chk("m_imm", bus.alu_imm, m_imm);
      chk("m_pc", bus.alu_pc, m_pc);
      chk("m_rob", bus.alu_rob_pos, m_rob);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                       input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                       input logic [31:0] imm, input logic [3:0] rob);
    bus.issue_opcode = op; bus.issue_funct3 = f3; bus.issue_funct7 = rob[0];
    bus.issue_rs1_ready = r1; bus.issue_rs1_val = v1; bus.issue_rs1_tag = t1;
    bus.issue_rs2_ready = r2; bus.issue_rs2_val = v2; bus.issue_rs2_tag = t2;
    bus.issue_imm = imm; bus.issue_pc = 32'h1000 + {28'd0, rob} * 4; bus.issue_rob_pos = rob;
    bus.issue_valid = 1;
    @(negedge clk);
    bus.issue_valid = 0;
  endtask

  task automatic acdb(input logic [3:0] tag, input logic [31:0] val);
    bus.alu_cdb_valid = 1; bus.alu_cdb_rob_pos = tag; bus.alu_cdb_val = val;
    @(negedge clk);
    bus.alu_cdb_valid = 0;
  endtask

  task automatic at_edge();
    @(posedge clk); #2;
  endtask

  initial begin
    bus.issue_valid = 0; bus.alu_cdb_valid = 0; bus.lsb_cdb_valid = 0;
    bus.alu_cdb_rob_pos = 0; bus.alu_cdb_val = 0; bus.lsb_cdb_rob_pos = 0; bus.lsb_cdb_val = 0;
    issue(ADDI, 0, 1, 0, 0, 1, 0, 0, 0, 0);  // ignored: held in reset
    @(negedge clk);
    chk("rst_alu_en", bus.alu_en, 0);
    chk("rst_rs_full", bus.rs_full, 0);
    chk("rst_rob", bus.alu_rob_pos, 0);
    rst = 0;
    @(negedge clk);

    // addi rob 3, rs1 = 5, imm 7
    issue(ADDI, 0, 1, 5, 0, 1, 0, 0, 7, 3);
    at_edge();
    chk("t1_en", bus.alu_en, 1); chk("t1_val1", bus.alu_val1, 5);
    chk("t1_imm", bus.alu_imm, 7); chk("t1_rob", bus.alu_rob_pos, 3); chk("t1_full", bus.rs_full, 0);
    @(negedge clk);

    // add rob 4 waits on tag 2
    issue(ADD, 0, 0, 0, 2, 1, 1, 0, 0, 4);
    repeat (2) @(negedge clk);
    bus.alu_cdb_valid = 1; bus.alu_cdb_rob_pos = 2; bus.alu_cdb_val = 32'h10;
    at_edge();
    chk("t2_no_same_cycle", bus.alu_en, 0);
    @(negedge clk); bus.alu_cdb_valid = 0;
    at_edge();
    chk("t2_en", bus.alu_en, 1); chk("t2_val1", bus.alu_val1, 32'h10); chk("t2_rob", bus.alu_rob_pos, 4);
    @(negedge clk);

    // rs2 tag 6 captured from LSB CDB in the issue cycle
    bus.lsb_cdb_valid = 1; bus.lsb_cdb_rob_pos = 6; bus.lsb_cdb_val = 32'hAB;
    issue(ADD, 0, 1, 3, 0, 0, 0, 6, 0, 5);
    bus.lsb_cdb_valid = 0;
    at_edge();
    chk("t3_en", bus.alu_en, 1); chk("t3_val2", bus.alu_val2, 32'hAB); chk("t3_val1", bus.alu_val1, 3);
    @(negedge clk);

    // fill all 16 waiting on tag 1, 17th dropped, then drain
    for (int i = 0; i < N; i++) issue(ADD, 3'(i), 0, 0, 1, 1, i, 0, i, 4'(i));
    chk("t4_full", bus.rs_full, 1);
    issue(ADDI, 0, 1, 32'hDEAD, 0, 1, 0, 0, 0, 15);
    chk("t4_full_after_drop", bus.rs_full, 1);
    acdb(1, 32'h55);
    for (int i = 0; i < N; i++) begin
      at_edge();
      chk("t4_disp_en", bus.alu_en, 1);
      chk("t4_disp_rob", bus.alu_rob_pos, i);
      chk("t4_disp_val1", bus.alu_val1, 32'h55);
      if (i == 0) chk("t4_full_drop", bus.rs_full, 0);
    end
    at_edge();
    chk("t4_drained", bus.alu_en, 0);
    @(negedge clk);

    // age: rob 9 in idx 5 is older than rob 2 refilled into idx 0
    for (int i = 0; i < 5; i++) issue(ADD, 0, 0, 0, 12, 1, 0, 0, 0, 4'(i));
    issue(ADD, 0, 0, 0, 13, 1, 0, 0, 0, 9);
    acdb(12, 32'h1);
    repeat (6) @(negedge clk);
    issue(ADD, 0, 0, 0, 13, 1, 0, 0, 0, 2);
    acdb(13, 32'h77);
    at_edge();
    chk("t5_first_rob", bus.alu_rob_pos, AGE ? 32'd9 : 32'd2);
    at_edge();
    chk("t5_second_rob", bus.alu_rob_pos, AGE ? 32'd2 : 32'd9);
    @(negedge clk);

    // rollback with 5 busy, one about to dispatch
    for (int i = 0; i < 4; i++) issue(ADD, 0, 0, 0, 14, 1, 0, 0, 0, 4'(10 + i));
    issue(ADDI, 0, 1, 8, 0, 1, 0, 0, 1, 8);
    rollback = 1;
    at_edge();
    chk("rb_en", bus.alu_en, 0); chk("rb_full", bus.rs_full, 0); chk("rb_rob", bus.alu_rob_pos, 0);
    @(negedge clk); rollback = 0;
    acdb(14, 32'h5);
    for (int i = 0; i < 3; i++) begin at_edge(); chk("rb_quiet", bus.alu_en, 0); end
    @(negedge clk);

    // rdy low: CDB lost while frozen
    issue(ADD, 0, 1, 2, 0, 0, 0, 5, 0, 6);
    rdy = 0;
    acdb(5, 32'h99);
    @(negedge clk); rdy = 1;
    at_edge();
    chk("frz_lost_cdb", bus.alu_en, 0);
    @(negedge clk);
    acdb(5, 32'h31);
    at_edge();
    chk("frz_en", bus.alu_en, 1); chk("frz_val2", bus.alu_val2, 32'h31);
    @(negedge clk);

    // async reset mid-operation
    issue(ADDI, 0, 1, 11, 0, 1, 0, 0, 0, 1);
    issue(ADDI, 0, 1, 12, 0, 1, 0, 0, 0, 2);
    chk("pre_rst_en", bus.alu_en, 1);
    rst = 1; #1;
    chk("arst_en", bus.alu_en, 0); chk("arst_val1", bus.alu_val1, 0); chk("arst_full", bus.rs_full, 0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    issue(ADDI, 0, 1, 32'h42, 0, 1, 0, 0, 0, 7);
    at_edge();
    chk("post_rst_en", bus.alu_en, 1); chk("post_rst_val1", bus.alu_val1, 32'h42);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
